// File: rtl/noc_pkg.sv
// Shared NoC definitions: output-port encodings, flit type codes, field widths,
// per-VC state encoding and the dimension-ordered (XY) route function.
package noc_pkg;

    localparam int unsigned PORT_W      = 3;
    localparam int unsigned FLIT_TYPE_W = 2;

    typedef enum logic [2:0] {
        PORT_N       = 3'b000,
        PORT_S       = 3'b001,
        PORT_E       = 3'b010,
        PORT_W_DIR   = 3'b011,
        PORT_L       = 3'b100,
        PORT_INVALID = 3'b111
    } port_e;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        VC_IDLE   = 2'd0,
        VC_ROUTE  = 2'd1,
        VC_ACTIVE = 2'd2
    } vc_state_e;

    function automatic logic is_head(input logic [FLIT_TYPE_W-1:0] t);
        return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
    endfunction

    function automatic logic is_tail(input logic [FLIT_TYPE_W-1:0] t);
        return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
    endfunction

    // X first, then Y; coordinates are compared unsigned.
    function automatic port_e xy_route(input logic [31:0] dest_x, input logic [31:0] dest_y,
                                       input logic [31:0] here_x, input logic [31:0] here_y);
        if (dest_x > here_x)      return PORT_E;
        else if (dest_x < here_x) return PORT_W_DIR;
        else if (dest_y > here_y) return PORT_S;
        else if (dest_y < here_y) return PORT_N;
        else                      return PORT_L;
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single-VC flit buffer: DEPTH entries of DSIZE bits, first-word-fall-through front.
// A push while full is dropped even if a pop happens in the same cycle.
module vc_fifo #(
    parameter int unsigned DSIZE = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [DSIZE-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [DSIZE-1:0] o_front
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DSIZE-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_front   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/vc_input_unit.sv
// Router input port: NUM_VC flit buffers, each with an IDLE/ROUTE/ACTIVE packet FSM,
// XY route computation and a registered switch output. Optional sticky per-VC error
// flags are built when VC_INPUT_UNIT_ERR_CHECK_EN is defined.
module vc_input_unit
    import noc_pkg::*;
#(
    parameter int unsigned MSB_SLOT = 5,
    parameter int unsigned DSIZE    = 1 << MSB_SLOT,
    parameter int unsigned RRSIZE   = 1 << (MSB_SLOT - 2),
    parameter logic [2:0]  PORT     = 3'd0,
    parameter logic [RRSIZE-1:0] ROUTER_X = '0,
    parameter logic [RRSIZE-1:0] ROUTER_Y = '0,
    parameter int unsigned NUM_VC   = 2,
    parameter int unsigned DEPTH    = 4,
    localparam int unsigned VCW     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DSIZE-1:0]         data_in,
    input  logic                     valid_in,
    input  logic [VCW-1:0]           vc_in,
    output logic [NUM_VC-1:0]        credit_out,
    output logic [NUM_VC-1:0]        vc_req,
    output logic [PORT_W*NUM_VC-1:0] vc_port,
    input  logic [NUM_VC-1:0]        vc_grant,
    output logic [DSIZE-1:0]         data_out,
    output logic                     data_valid,
    output logic [VCW-1:0]           vc_out
`ifdef VC_INPUT_UNIT_ERR_CHECK_EN
   ,output logic [NUM_VC-1:0]        err
`endif
);

    logic [NUM_VC-1:0] w_push;
    logic [NUM_VC-1:0] w_full;
    logic [NUM_VC-1:0] w_empty;
    logic [NUM_VC-1:0] w_req;
    logic [NUM_VC-1:0] w_discard;
    logic [NUM_VC-1:0] w_gnt_oh;
    logic [NUM_VC-1:0] w_sw_pop;
    logic [NUM_VC-1:0] w_pop;
    logic [DSIZE-1:0]  w_front [NUM_VC];
    logic [DSIZE-1:0]  w_sel_data;
    logic [VCW-1:0]    w_sel_vc;
    logic              w_unused_port;

    // The input port id does not affect XY routing decisions here.
    assign w_unused_port = ^PORT;

    // Lowest set grant bit wins; a grant to a non-requesting VC is ignored.
    assign w_gnt_oh = vc_grant & (~vc_grant + NUM_VC'(1));
    assign w_sw_pop = w_gnt_oh & w_req;
    assign w_pop    = w_sw_pop | w_discard;
    assign vc_req   = w_req;

    for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
        vc_state_e              r_state;
        logic [PORT_W-1:0]      r_port;
        logic [FLIT_TYPE_W-1:0] w_type;

        assign w_type     = w_front[gi][DSIZE-1 -: FLIT_TYPE_W];
        assign w_push[gi] = valid_in && (32'(vc_in) == gi);

        vc_fifo #(
            .DSIZE (DSIZE),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .i_push  (w_push[gi]),
            .i_data  (data_in),
            .i_pop   (w_pop[gi]),
            .o_full  (w_full[gi]),
            .o_empty (w_empty[gi]),
            .o_front (w_front[gi])
        );

        assign w_req[gi]     = (r_state == VC_ACTIVE) && !w_empty[gi];
        // Body/tail flits reaching the front outside a packet are orphans.
        assign w_discard[gi] = (r_state == VC_IDLE) && !w_empty[gi] && !is_head(w_type);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_state <= VC_IDLE;
                r_port  <= '0;
            end else begin
                case (r_state)
                    VC_IDLE: begin
                        if (!w_empty[gi] && is_head(w_type)) r_state <= VC_ROUTE;
                    end
                    VC_ROUTE: begin
                        r_port  <= xy_route(32'(w_front[gi][2*RRSIZE-1:RRSIZE]),
                                            32'(w_front[gi][RRSIZE-1:0]),
                                            32'(ROUTER_X), 32'(ROUTER_Y));
                        r_state <= VC_ACTIVE;
                    end
                    VC_ACTIVE: begin
                        if (w_sw_pop[gi] && is_tail(w_type)) r_state <= VC_IDLE;
                    end
                    default: r_state <= VC_IDLE;
                endcase
            end
        end

        assign vc_port[PORT_W*gi +: PORT_W] = r_port;
    end

    always_comb begin
        w_sel_data = '0;
        w_sel_vc   = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (w_sw_pop[i]) begin
                w_sel_data = w_front[i];
                w_sel_vc   = VCW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit_out <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            vc_out     <= '0;
        end else begin
            credit_out <= w_pop;
            data_valid <= |w_sw_pop;
            if (|w_sw_pop) begin
                data_out <= w_sel_data;
                vc_out   <= w_sel_vc;
            end
        end
    end

`ifdef VC_INPUT_UNIT_ERR_CHECK_EN
    logic [NUM_VC-1:0] r_err;

    // Sticky until reset: overflow drops and discarded orphans.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_err <= '0;
        else        r_err <= r_err | (w_push & w_full) | w_discard;
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_vc_input_unit.sv
// Randomized scoreboard bench for vc_input_unit (3 VCs, depth 4, router at (1,1)).
// Honours VC_INPUT_UNIT_ERR_CHECK_EN to also check the err flags.
module tb_vc_input_unit;

    localparam int NVC   = 3;
    localparam int DEPTH = 4;
    localparam int RX    = 1;
    localparam int RY    = 1;
    localparam int M_IDLE  = 0;
    localparam int M_ROUTE = 1;
    localparam int M_ACT   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_in = '0;
    logic        valid_in = 1'b0;
    logic [1:0]  vc_in = '0;
    logic [2:0]  vc_grant = '0;
    logic [2:0]  credit_out;
    logic [2:0]  vc_req;
    logic [8:0]  vc_port;
    logic [31:0] data_out;
    logic        data_valid;
    logic [1:0]  vc_out;
`ifdef VC_INPUT_UNIT_ERR_CHECK_EN
    logic [2:0]  err;
`endif

    vc_input_unit #(
        .MSB_SLOT (5),
        .PORT     (3'd0),
        .ROUTER_X (8'(RX)),
        .ROUTER_Y (8'(RY)),
        .NUM_VC   (NVC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .vc_in      (vc_in),
        .credit_out (credit_out),
        .vc_req     (vc_req),
        .vc_port    (vc_port),
        .vc_grant   (vc_grant),
        .data_out   (data_out),
        .data_valid (data_valid),
        .vc_out     (vc_out)
`ifdef VC_INPUT_UNIT_ERR_CHECK_EN
       ,.err        (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  vc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mq[NVC][$];
    int          mph[NVC];
    logic [2:0]  mport[NVC];
    logic [2:0]  mcred;
    logic [2:0]  merr;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [1:0] t, input int dx, input int dy,
                                       input logic [31:0] pl);
        return {t, pl[13:0], 8'(dx), 8'(dy)};
    endfunction

    function automatic logic [31:0] rnd_flit();
        int r;
        logic [1:0] t;
        r = $urandom_range(0, 99);
        t = (r < 35) ? 2'b01 : (r < 65) ? 2'b00 : (r < 85) ? 2'b10 : 2'b11;
        return mk(t, $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
    endfunction

    function automatic logic [2:0] ref_route(input logic [31:0] f);
        int dx, dy;
        dx = int'(f[15:8]);
        dy = int'(f[7:0]);
        if (dx > RX) return 3'b010;
        if (dx < RX) return 3'b011;
        if (dy > RY) return 3'b001;
        if (dy < RY) return 3'b000;
        return 3'b100;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NVC; i++) begin
            mq[i].delete();
            mph[i]   = M_IDLE;
            mport[i] = 3'b000;
        end
        mcred = '0;
        merr  = '0;
    endfunction

    // Compare the current cycle, apply inputs, advance the model across the next edge.
    task automatic cycle(input logic v, input logic [1:0] vc, input logic [31:0] d,
                         input logic [2:0] g);
        logic [2:0]  req;
        logic [2:0]  full;
        logic [1:0]  t;
        logic [31:0] f;
        int          w;
        for (int i = 0; i < NVC; i++) begin
            req[i]  = (mph[i] == M_ACT) && (mq[i].size() > 0);
            full[i] = (mq[i].size() == DEPTH);
        end
        check("vc_req", 32'(vc_req), 32'(req));
        check("vc_port", 32'(vc_port), 32'({mport[2], mport[1], mport[0]}));
        check("credit_out", 32'(credit_out), 32'(mcred));
`ifdef VC_INPUT_UNIT_ERR_CHECK_EN
        check("err", 32'(err), 32'(merr));
`endif
        valid_in = v;
        vc_in    = vc;
        data_in  = d;
        vc_grant = g;

        w = -1;
        for (int i = 0; i < NVC; i++) if (g[i] && w < 0) w = i;
        mcred = '0;
        for (int i = 0; i < NVC; i++) begin
            if (mph[i] == M_IDLE) begin
                if (mq[i].size() > 0) begin
                    t = mq[i][0][31:30];
                    if (t == 2'b01 || t == 2'b11) mph[i] = M_ROUTE;
                    else begin
                        void'(mq[i].pop_front());
                        mcred[i] = 1'b1;
                        merr[i]  = 1'b1;
                    end
                end
            end else if (mph[i] == M_ROUTE) begin
                mport[i] = ref_route(mq[i][0]);
                mph[i]   = M_ACT;
            end else if (w == i && mq[i].size() > 0) begin
                f = mq[i].pop_front();
                exp_q.push_back({f, 2'(i)});
                mcred[i] = 1'b1;
                t = f[31:30];
                if (t == 2'b10 || t == 2'b11) mph[i] = M_IDLE;
            end
        end
        if (v && int'(vc) < NVC) begin
            if (full[vc]) merr[vc] = 1'b1;
            else          mq[vc].push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [2:0] g);
        for (int k = 0; k < n; k++) cycle(1'b0, 2'd0, 32'd0, g);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " credit_out"}, 32'(credit_out), 32'd0);
        check({tag, " vc_req"}, 32'(vc_req), 32'd0);
        check({tag, " vc_port"}, 32'(vc_port), 32'd0);
        check({tag, " data_out"}, data_out, 32'd0);
        check({tag, " data_valid"}, 32'(data_valid), 32'd0);
        check({tag, " vc_out"}, 32'(vc_out), 32'd0);
`ifdef VC_INPUT_UNIT_ERR_CHECK_EN
        check({tag, " err"}, 32'(err), 32'd0);
`endif
    endtask

    // Asynchronous reset taken between edges, held two cycles, released on a negedge.
    task automatic mid_reset();
        #2;
        reset    = 1'b0;
        valid_in = 1'b0;
        vc_grant = '0;
        #1;
        check_reset_outputs("midrst");
        check("pending at reset", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        model_clear();
        @(negedge clk);
        @(negedge clk);
        check("vc_req in reset", 32'(vc_req), 32'd0);
        reset = 1'b1;
    endtask

    // Scoreboard monitor: every presented flit must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset && data_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected data: got 0x%08h vc %0d, expected none", data_out, vc_out);
            end else begin
                e = exp_q.pop_front();
                check("data_out", data_out, e.data);
                check("vc_out", 32'(vc_out), 32'(e.vc));
            end
        end
    end

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;

        // Single flit on VC0, then granted.
        cycle(1'b1, 2'd0, 32'hC001_0001, 3'b000);
        idle(3, 3'b000);
        idle(2, 3'b001);

        // Head/body/tail streamed under constant grant.
        cycle(1'b1, 2'd0, 32'h4000_0100, 3'b001);
        cycle(1'b1, 2'd0, mk(2'b00, 0, 0, 32'h55), 3'b001);
        cycle(1'b1, 2'd0, mk(2'b10, 0, 0, 32'h66), 3'b001);
        idle(6, 3'b001);
        cycle(1'b1, 2'd2, mk(2'b11, 1, 1, 32'h77), 3'b000);
        idle(4, 3'b100);

        // Five writes to a depth-4 VC without grant, then drain.
        cycle(1'b1, 2'd1, mk(2'b01, 2, 2, 32'h1), 3'b000);
        for (int k = 0; k < 3; k++) cycle(1'b1, 2'd1, mk(2'b00, 0, 0, 32'(k + 2)), 3'b000);
        cycle(1'b1, 2'd1, mk(2'b10, 0, 0, 32'h9), 3'b000);
        idle(3, 3'b000);
        idle(6, 3'b010);

        // Interleaved heads on VC0 (east) and VC1 (west), both granted.
        cycle(1'b1, 2'd0, mk(2'b01, 2, 0, 32'hA), 3'b000);
        cycle(1'b1, 2'd1, mk(2'b01, 0, 2, 32'hB), 3'b000);
        cycle(1'b1, 2'd0, mk(2'b10, 0, 0, 32'hC), 3'b000);
        cycle(1'b1, 2'd1, mk(2'b10, 0, 0, 32'hD), 3'b000);
        idle(2, 3'b000);
        idle(6, 3'b011);

        // Out-of-range VC is dropped.
        cycle(1'b1, 2'd3, mk(2'b11, 2, 2, 32'hE), 3'b111);
        idle(3, 3'b111);

        // Reset mid-packet, then an orphan body after release.
        cycle(1'b1, 2'd2, mk(2'b01, 1, 0, 32'hF), 3'b000);
        cycle(1'b1, 2'd2, mk(2'b00, 0, 0, 32'h10), 3'b000);
        idle(3, 3'b000);
        mid_reset();
        cycle(1'b1, 2'd0, mk(2'b00, 0, 0, 32'h11), 3'b000);
        idle(3, 3'b000);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            logic [2:0] g;
            g = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
            cycle(($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)), rnd_flit(), g);
        end

        idle(20, 3'b111);
        idle(3, 3'b000);
        #1;
        check("drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
